// File: rtl/si_period_meter_pkg.sv
// si_period_meter_pkg
// Shared definitions for the si period meter.
// Contents:
//   - the FSM state encoding
//   - default clock rate and result width
//   - tick-counter width helpers
package si_period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    COUNT     = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam int CLK_PER_US_DEF = 50;
  localparam int PRD_W_DEF      = 20;
  localparam int TICK_W         = $clog2(CLK_PER_US_DEF);

  // Counter width for an arbitrary CLK_PER_US override.
  // $clog2(1) is 0, so the width is clamped to at least one bit.
  function automatic int tick_width(input int clk_per_us);
    return (clk_per_us > 1) ? $clog2(clk_per_us) : 1;
  endfunction

endpackage

// File: rtl/si_period_meter_edge_detect.sv
// edge_detect
// Rising-edge detector for the asynchronous si input.
// When SI_SYNC_EN is defined, si first passes through a two-flop
// synchronizer; rise then fires 2 clk later than in the default build.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset
//   si    - raw square-wave input
//   rise  - high for one cycle on a 0->1 transition of the (synchronized) si
module edge_detect
  import si_period_meter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic si,
  output logic rise
);

  logic si_s;
  logic si_d;

`ifdef SI_SYNC_EN
  logic si_m;

  always_ff @(posedge clk) begin
    if (reset) begin
      si_m <= 1'b0;
      si_s <= 1'b0;
    end else begin
      si_m <= si;
      si_s <= si_m;
    end
  end
`else
  assign si_s = si;
`endif

  always_ff @(posedge clk) begin
    if (reset) si_d <= 1'b0;
    else       si_d <= si_s;
  end

  assign rise = si_s & ~si_d;

endmodule

// File: rtl/si_period_meter.sv
// si_period_meter
// Measures the period of the low-frequency input si in microseconds.
// It counts whole microseconds between two consecutive rising edges of si.
// Optional build macro: SI_SYNC_EN. When defined, si is synchronized
// before edge detection. The result is the same in both builds, only
// the latency changes.
// Ports:
//   clk       - system clock, CLK_PER_US cycles per microsecond
//   reset     - synchronous active-high reset
//   start     - measurement request, taken while ready is high
//   si        - asynchronous square-wave input
//   ready     - high only while idle
//   done_tick - one-cycle pulse when prd/ovf are valid
//   prd       - measured period in microseconds (saturating)
//   ovf       - prd saturated during the last measurement
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for start; prd/ovf hold the last result
// WAIT_EDGE | armed, waiting for the first rising edge of si
// COUNT     | counting microseconds until the next rising edge
// DONE      | result valid, done_tick pulses, back to IDLE
module si_period_meter
  import si_period_meter_pkg::*;
#(
  parameter int CLK_PER_US = CLK_PER_US_DEF,
  parameter int PRD_W      = PRD_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             si,
  output logic             ready,
  output logic             done_tick,
  output logic [PRD_W-1:0] prd,
  output logic             ovf
);

  localparam int               TW        = tick_width(CLK_PER_US);
  localparam logic [TW-1:0]    TICK_LAST = TW'(CLK_PER_US - 1);
  localparam logic [PRD_W-1:0] PRD_MAX   = '1;

  state_t           state_q, state_d;
  logic [TW-1:0]    tick_q;
  logic [PRD_W-1:0] prd_q;
  logic             ovf_q;
  logic             rise;
  logic             wrap;

  edge_detect u_edge (
    .clk   (clk),
    .reset (reset),
    .si    (si),
    .rise  (rise)
  );

  assign wrap = (tick_q == TICK_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start) state_d = WAIT_EDGE;
      WAIT_EDGE: if (rise)  state_d = COUNT;
      COUNT:     if (rise)  state_d = DONE;
      DONE:                 state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // The datapath follows the current state. In COUNT, the wrap
  // increment lands on the same edge as the move to DONE, so a
  // coincident rise captures the incremented value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      prd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            tick_q <= '0;
            prd_q  <= '0;
            ovf_q  <= 1'b0;
          end
        end
        WAIT_EDGE: begin
          if (rise) begin
            tick_q <= '0;
            prd_q  <= '0;
          end
        end
        COUNT: begin
          if (wrap) begin
            tick_q <= '0;
            if (prd_q == PRD_MAX) ovf_q <= 1'b1;
            else                  prd_q <= prd_q + 1'b1;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready     = (state_q == IDLE);
  assign done_tick = (state_q == DONE);
  assign prd       = prd_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_si_period_meter.sv
// tb_si_period_meter
// Self-checking bench for si_period_meter.
// Two instances are used, both at 4 clk per us so periods stay short:
//   dut1 - PRD_W 20
//   dut2 - PRD_W 4, which saturates quickly
// The expected prd is floor(period_us) from a simple arithmetic model,
// clamped to 2^PRD_W-1, with ovf set when the clamp engages.
module tb_si_period_meter;

  localparam int CPU = 4;
`ifdef SI_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start1 = 1'b0;
  logic        start2 = 1'b0;
  logic        si;
  logic        ready1, done1, ovf1;
  logic [19:0] prd1;
  logic        ready2, done2, ovf2;
  logic [3:0]  prd2;

  int tests = 0;
  int fails = 0;

  // si generator: toggles every gen_half clocks; gen_half==0 hands si to man_si.
  int   gen_half = 0;
  int   gen_cnt = 0;
  logic gen_si = 1'b0;
  logic man_si = 1'b0;

  assign si = (gen_half > 0) ? gen_si : man_si;

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (gen_half == 0) begin
      gen_cnt = 0;
      gen_si  = 1'b0;
    end else if (gen_cnt >= gen_half - 1) begin
      gen_cnt = 0;
      gen_si  = ~gen_si;
    end else begin
      gen_cnt = gen_cnt + 1;
    end
  end

  si_period_meter #(.CLK_PER_US(CPU), .PRD_W(20)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .si(si),
    .ready(ready1), .done_tick(done1), .prd(prd1), .ovf(ovf1)
  );

  si_period_meter #(.CLK_PER_US(CPU), .PRD_W(4)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .si(si),
    .ready(ready2), .done_tick(done2), .prd(prd2), .ovf(ovf2)
  );

  typedef struct {
    int which;
    int half;
    int prd;
    int ovf;
  } vec_t;

  vec_t vecs[8];

  function automatic int g_done(input int w);
    return (w == 1) ? int'(done1) : int'(done2);
  endfunction
  function automatic int g_ready(input int w);
    return (w == 1) ? int'(ready1) : int'(ready2);
  endfunction
  function automatic int g_prd(input int w);
    return (w == 1) ? int'(prd1) : int'(prd2);
  endfunction
  function automatic int g_ovf(input int w);
    return (w == 1) ? int'(ovf1) : int'(ovf2);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_start(input int w, input logic v);
    if (w == 1) start1 = v;
    else        start2 = v;
  endtask

  task automatic wait_done(input int w, input int budget, output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    while (cyc < budget && !ok) begin
      @(negedge clk);
      cyc++;
      if (g_done(w) == 1) ok = 1'b1;
    end
  endtask

  task automatic measure(input int w, input int half, input int eprd, input int eovf,
                         input string name);
    int  cyc;
    bit  ok;
    gen_half = 0;
    repeat (3) @(negedge clk);
    gen_half = half;
    repeat (6) @(negedge clk);
    cyc = 0;
    while (g_ready(w) == 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    set_start(w, 1'b1);
    @(negedge clk);
    set_start(w, 1'b0);
    wait_done(w, 4 * half + 40, cyc, ok);
    if (!ok) begin
      check({name, "_timeout"}, 0, 1);
    end else begin
      check({name, "_prd"}, g_prd(w), eprd);
      check({name, "_ovf"}, g_ovf(w), eovf);
      @(negedge clk);
      check({name, "_ready_after"}, g_ready(w), 1);
      check({name, "_tick_width"}, g_done(w), 0);
      repeat (3) @(negedge clk);
      check({name, "_prd_hold"}, g_prd(w), eprd);
    end
  endtask

  initial begin
    int  cyc;
    bit  ok;
    int  seen;
    int  w, half, n, maxv, eprd, eovf;

    vecs[0] = '{1, 800, 400, 0};
    vecs[1] = '{1, 2000, 1000, 0};
    vecs[2] = '{1, 7, 3, 0};
    vecs[3] = '{1, 2, 1, 0};
    vecs[4] = '{1, 1, 0, 0};
    vecs[5] = '{2, 40, 15, 1};
    vecs[6] = '{2, 24, 12, 0};
    vecs[7] = '{2, 32, 15, 1};

    repeat (4) @(negedge clk);
    check("rst_ready1", ready1, 1);
    check("rst_done1", done1, 0);
    check("rst_prd1", prd1, 0);
    check("rst_ovf1", ovf1, 0);
    check("rst_ready2", ready2, 1);
    check("rst_prd2", prd2, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      measure(vecs[i].which, vecs[i].half, vecs[i].prd, vecs[i].ovf, $sformatf("vec%0d", i));

    for (int i = 0; i < 8; i++) begin
      w    = (($urandom & 1) == 0) ? 1 : 2;
      half = (w == 1) ? int'($urandom_range(1, 300)) : int'($urandom_range(1, 60));
      maxv = (w == 1) ? (1 << 20) - 1 : (1 << 4) - 1;
      n    = (2 * half) / CPU;
      eprd = (n > maxv) ? maxv : n;
      eovf = (n > maxv) ? 1 : 0;
      measure(w, half, eprd, eovf, $sformatf("rnd%0d_h%0d", i, half));
    end

    // start held high: consecutive 1 ms results
    gen_half = 0;
    repeat (3) @(negedge clk);
    gen_half = 2000;
    repeat (6) @(negedge clk);
    start1 = 1'b1;
    for (int r = 0; r < 2; r++) begin
      wait_done(1, 3 * 4000 + 50, cyc, ok);
      if (!ok) begin
        check($sformatf("held%0d_timeout", r), 0, 1);
      end else begin
        check($sformatf("held%0d_prd", r), prd1, 1000);
        check($sformatf("held%0d_ovf", r), ovf1, 0);
        @(negedge clk);
        check($sformatf("held%0d_tick_width", r), done1, 0);
        check($sformatf("held%0d_ready", r), ready1, 1);
      end
    end
    start1 = 1'b0;
    repeat (2) @(negedge clk);

    // si constant after start: stays armed, then a manual period of 10 us
    gen_half = 0;
    man_si   = 1'b0;
    repeat (5) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (done1) seen++;
    end
    check("hold_no_done", seen, 0);
    check("hold_not_ready", ready1, 0);
    man_si = 1'b1;
    repeat (20) @(negedge clk);
    man_si = 1'b0;
    repeat (20) @(negedge clk);
    man_si = 1'b1;
    wait_done(1, 10, cyc, ok);
    check("latency_cycles", ok ? cyc : -1, LAT);
    check("latency_prd", prd1, 10);
    @(negedge clk);
    man_si = 1'b0;
    repeat (5) @(negedge clk);

    // reset in the middle of COUNT, 150 us after the first rise
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (5) @(negedge clk);
    man_si = 1'b1;
    repeat (600) @(negedge clk);
    check("mid_ready", ready1, 0);
    check("mid_prd", prd1, (600 - LAT) / CPU);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_prd", prd1, 0);
    check("rstmid_ready", ready1, 1);
    check("rstmid_done", done1, 0);
    check("rstmid_ovf", ovf1, 0);
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      if (k % 10 == 0) man_si = ~man_si;
      @(negedge clk);
      if (done1) seen++;
    end
    check("rstmid_no_done", seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/si_period_meter.md
SI_PERIOD_METER -- requirements
Module: si_period_meter

Interface
REQ-001 Parameter CLK_PER_US, default 50: clk cycles per microsecond (50 MHz clk).
REQ-002 Parameter PRD_W, default 20: width of the period result in microseconds.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  level or pulse; a measurement request is taken when high in IDLE.
REQ-006 si  input  1  external low-frequency square-wave input, asynchronous to clk.
REQ-007 ready  output  1  high only in IDLE.
REQ-008 done_tick  output  1  one-cycle pulse when prd is valid.
REQ-009 prd  output  PRD_W  measured si period in microseconds; feeds the downstream divider.
REQ-010 ovf  output  1  period saturated at all-ones during the last measurement.

Function
REQ-011 si edge detector: registered copy si_d; rise = si_s & ~si_d, where si_s is the (optionally synchronized) si.
REQ-012 FSM states: IDLE, WAIT_EDGE, COUNT, DONE.
REQ-013 IDLE and start=1 -> WAIT_EDGE next cycle; clear prd, ovf and the tick counter.
REQ-014 IDLE and start=0 -> stay; prd and ovf hold the last result.
REQ-015 WAIT_EDGE on rise -> COUNT; tick counter and prd = 0; otherwise stay indefinitely.
REQ-016 COUNT: tick counter counts 0..CLK_PER_US-1 and wraps; on each wrap prd increments by 1.
REQ-017 prd saturates at 2^PRD_W-1 and ovf is set; further wraps do not change prd.
REQ-018 COUNT on rise -> DONE; if rise and wrap coincide, the increment is applied before the capture.
REQ-019 DONE: done_tick=1 for exactly this cycle, then IDLE unconditionally.
REQ-020 start is ignored outside IDLE; start held high through DONE re-arms on the first IDLE cycle.
REQ-021 Accuracy: prd = floor(true period / 1 us) with a jitter of ±1 count; no division inside the block.
REQ-022 prd and ovf stay stable from done_tick until the next accepted start.

Reset
REQ-023 reset=1 forces IDLE: ready=1, done_tick=0, prd=0, ovf=0, tick counter=0, si_d=0, and the synchronizer flops=0.
REQ-024 reset has priority over every other event; reset mid-measurement discards the partial count.

Configuration
REQ-025 Macro SI_SYNC_EN defined: si passes through a two-flop synchronizer before the edge detector; edge recognition is 3 clk after the si transition.
REQ-026 SI_SYNC_EN undefined: si feeds the edge detector directly; recognition is 1 clk after the transition. The measured prd is identical in both builds.

Structure
REQ-027 A shared package holds the FSM state enum, CLK_PER_US and PRD_W defaults, and the tick-counter width constant, computed as $clog2(CLK_PER_US).
REQ-028 One sub-module, edge_detect, contains the optional synchronizer and the rise logic; the FSM and counters stay in si_period_meter.

Verification
REQ-029 si toggles every 200 us; start pulses 1 clk in IDLE -> done_tick once, prd=400, ovf=0, ready returns high the next cycle.
REQ-030 si period 1 ms with start held high continuously -> back-to-back results of prd=1000, each preceded by a single done_tick.
REQ-031 PRD_W=4 with si period 20 us -> prd=15, ovf=1.
REQ-032 Assert reset during COUNT at 150 us -> next cycle prd=0, ready=1, no done_tick.
REQ-033 si held constant after start -> FSM remains in WAIT_EDGE and done_tick is never asserted; a rise later begins a normal measurement.
REQ-034 Run the bench with and without SI_SYNC_EN -> same prd; done_tick is 2 cycles later when the macro is defined.
